// File: rtl/stream_pkg.sv
// stream_pkg
// Shared types and constants for the stochastic-stream decoder.
//   decoder_state_t       : FSM states IDLE / COUNT / DONE
//   STREAM_WINDOW_DEFAULT : default measurement window length
//   decoder_out_w()       : output width for the current build
// Build option: STREAM_DECODER_BIPOLAR_EN widens the output by one sign bit.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } decoder_state_t;

  localparam int STREAM_WINDOW_DEFAULT = 256;

  // Unipolar results need room for 0..window; bipolar adds a sign bit
  // so that -window..+window is representable.
  function automatic int decoder_out_w(input int window);
`ifdef STREAM_DECODER_BIPOLAR_EN
    return $clog2(window + 1) + 1;
`else
    return $clog2(window + 1);
`endif
  endfunction

endpackage

// File: rtl/stream_decoder_if.sv
// stream_decoder_if
// Result handshake between the decoder and its consumer.
//   out_valid : result available (driven by master)
//   out_value : decoded result, W bits (driven by master)
//   out_ready : consumer accepts the result (driven by slave)
// Modports: master (decoder side), slave (consumer side).
interface stream_decoder_if
  import stream_pkg::*;
#(
  parameter int W = decoder_out_w(STREAM_WINDOW_DEFAULT)
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;

  modport master (
    output out_valid,
    output out_value,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    output out_ready
  );

endinterface

// File: rtl/ones_accumulator.sv
// ones_accumulator
// Counts ones and elapsed cycles over one measurement window.
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : zero both counters (wins over en)
//   en         : accumulate bit_in this cycle
//   bit_in     : stream sample
//   count      : ones so far including the current bit_in
//   last       : the current cycle is the final sample of the window
module ones_accumulator #(
  parameter int WINDOW  = 256,
  parameter int COUNT_W = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [COUNT_W-1:0] count,
  output logic               last
);

  localparam int CYC_W = $clog2(WINDOW);

  logic [COUNT_W-1:0] ones_cnt;
  logic [CYC_W-1:0]   cyc_cnt;

  // ones_cnt tops out at WINDOW, which COUNT_W always holds, so no
  // saturation is needed. cyc_cnt may wrap after the last sample, but
  // the FSM has left COUNT by then.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt <= '0;
      cyc_cnt  <= '0;
    end else if (clr) begin
      ones_cnt <= '0;
      cyc_cnt  <= '0;
    end else if (en) begin
      ones_cnt <= ones_cnt + COUNT_W'(bit_in);
      cyc_cnt  <= cyc_cnt + CYC_W'(1);
    end
  end

  // The final result must include the sample taken on the last cycle,
  // so count looks one sample ahead of the register.
  assign count = ones_cnt + COUNT_W'(bit_in);
  assign last  = (cyc_cnt == CYC_W'(WINDOW - 1));

endmodule

// File: rtl/stream_decoder.sv
// stream_decoder
// Converts a unipolar stochastic bitstream into a binary count over a
// window of WINDOW cycles and offers it on a valid/ready handshake.
//   clk, n_rst : clock, asynchronous active-low reset
//   stream_in  : bitstream from the neuron output
//   start      : single-cycle request to begin a window
//   busy       : high while a window is being accumulated
//   out        : stream_decoder_if.master (out_valid/out_value/out_ready)
// Build option STREAM_DECODER_BIPOLAR_EN: out_value becomes signed,
// COUNT_W+1 bits, equal to 2*ones - WINDOW; otherwise it is the raw
// unsigned ones count.
module stream_decoder
  import stream_pkg::*;
#(
  parameter int WINDOW  = STREAM_WINDOW_DEFAULT,
  parameter int COUNT_W = $clog2(WINDOW + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic stream_in,
  input  logic start,
  output logic busy,
  stream_decoder_if.master out
);

`ifdef STREAM_DECODER_BIPOLAR_EN
  localparam int OUT_W = COUNT_W + 1;
`else
  localparam int OUT_W = COUNT_W;
`endif

  decoder_state_t     state, next_state;
  logic               acc_clr, acc_en, acc_last, load;
  logic [COUNT_W-1:0] sum;
  logic [OUT_W-1:0]   result, value_q;

  ones_accumulator #(
    .WINDOW  (WINDOW),
    .COUNT_W (COUNT_W)
  ) u_acc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (stream_in),
    .count  (sum),
    .last   (acc_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // out_valid equals "in DONE", so a handshake in DONE is just out_ready.
  // A start in DONE without out_ready is dropped, not remembered.
  always_comb begin
    next_state = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = COUNT;
          acc_clr    = 1'b1;
        end
      end
      COUNT: begin
        acc_en = 1'b1;
        if (acc_last) begin
          next_state = DONE;
          load       = 1'b1;
        end
      end
      DONE: begin
        if (out.out_ready) begin
          if (start) begin
            next_state = COUNT;
            acc_clr    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Mode conversion happens only at the result load; the accumulator
  // always counts raw ones. Modular subtraction yields the two's
  // complement value directly.
`ifdef STREAM_DECODER_BIPOLAR_EN
  assign result = {sum, 1'b0} - OUT_W'(WINDOW);
`else
  assign result = sum;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    value_q <= '0;
    else if (load) value_q <= result;
  end

  assign busy          = (state == COUNT);
  assign out.out_valid = (state == DONE);
  assign out.out_value = value_q;

endmodule

// File: doc/stream_decoder.md
# stream_decoder

Downstream stage for a neuron: converts the neuron's unipolar stochastic bitstream back into a binary count by accumulating ones over a fixed window of clock cycles. The result is presented on a valid/ready output so a layer controller, readout register or comparator can consume it at its own pace. One instance per neuron output; its input is the neuron's registered output bit.

## Interface
- `WINDOW`, default 256: number of bitstream cycles per measurement; must be ≥ 2.
- `COUNT_W`, default `$clog2(WINDOW+1)`: width of the unsigned ones count.

- `clk`  input  1  system clock, rising edge.
- `n_rst`  input  1  asynchronous, active-low reset.
- `stream_in`  input  1  bitstream from the neuron output.
- `start`  input  1  single-cycle request to begin a measurement window.
- `busy`  output  1  high while a window is being accumulated.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer accepts the result.
- `out_value`  output  `COUNT_W` (or `COUNT_W+1` signed, see Configuration)  decoded value.

## Operation
- The FSM has three states: IDLE, COUNT and DONE. Reset enters IDLE.
- **IDLE**
  - `start`=1 moves to COUNT and clears `ones_cnt` and `cyc_cnt` to 0.
- **COUNT**
  - Each cycle, sample `stream_in`: `ones_cnt += stream_in` and `cyc_cnt += 1`.
  - On the cycle where `cyc_cnt == WINDOW-1`, that sample is the last. Next state is DONE.
  - `out_value` is loaded with the final sum, including the last sample, and `out_valid` is set.
  - `start` is ignored in COUNT.
- **DONE**
  - `out_value` and `out_valid` are held stable until `out_valid && out_ready`.
  - On handshake with `start`=0, go to IDLE; `out_valid` falls the next cycle.
  - On handshake with `start`=1 in the same cycle, go directly to COUNT with counters cleared (back-to-back windows).
  - `start` without a handshake is ignored; it is not queued.
- **Outputs and arithmetic**
  - `busy` = (state == COUNT).
  - `out_value` keeps its last result after the handshake until the next result is loaded.
  - `ones_cnt` never exceeds `WINDOW`, so there is no saturation or wrap.
  - `cyc_cnt` width is `$clog2(WINDOW)`.
- **Reset values:** state IDLE, `busy`=0, `out_valid`=0, `out_value`=0, both counters 0. Assertion of `n_rst` in any state, including mid-window, discards the partial count immediately.

## Timing
- `start` sampled high at edge t means `stream_in` is sampled at edges t+1 … t+WINDOW.
- `out_valid` is high after edge t+WINDOW, i.e. visible in cycle t+WINDOW+1.
- Latency from `start` to `out_valid` is WINDOW+1 cycles.
- Back-to-back throughput is one result per WINDOW+1 cycles when `out_ready` is held high and `start` is asserted in the handshake cycle.
- All outputs are registered; there is no combinational path from `stream_in`, `start` or `out_ready` to any output.
- Asynchronous reset assertion clears outputs without a clock edge. Deassertion is assumed synchronised upstream.

## Configuration
- `STREAM_DECODER_BIPOLAR_EN`
  - Defined: output uses bipolar decoding. `out_value` is signed, `COUNT_W+1` bits, equal to `2*ones_cnt - WINDOW`. Range is −WINDOW … +WINDOW.
  - Undefined: `out_value` is unsigned, `COUNT_W` bits, equal to `ones_cnt`.
  - FSM and timing are identical in both modes. The conversion happens at the DONE load, not in the accumulator.

## Structure
- The shared package `stream_pkg` holds:
  - the FSM state enum `decoder_state_t` (IDLE, COUNT, DONE);
  - the default window constant `STREAM_WINDOW_DEFAULT` = 256;
  - the function `decoder_out_w(window)` returning the output width for the current configuration.
- Sub-module `ones_accumulator`:
  - parameter `WINDOW`;
  - inputs `clr`, `en`, `bit_in`;
  - outputs `count`, `last`;
  - holds `ones_cnt`/`cyc_cnt`.
  - The top level contains the FSM, output register and mode conversion.

## Test plan
- WINDOW=8, `stream_in` held 1, `start` pulse → `busy` for 8 cycles, `out_valid` at cycle 9, `out_value`=8 (bipolar: +8).
- WINDOW=8, `stream_in` held 0 → `out_value`=0 (bipolar: −8); pattern 1010… → `out_value`=4 (bipolar: 0).
- `out_ready` low for 20 cycles after `out_valid` → `out_value`/`out_valid` stable throughout, and `start` pulses during the wait are ignored. Raising `out_ready` → `out_valid` drops the next cycle.
- `out_ready`=1 and `start`=1 in the handshake cycle with `stream_in`=1 → the next result arrives WINDOW+1 cycles later with value 8, and `busy` shows no IDLE gap.
- `n_rst` pulsed low at sample 5 of a window → all outputs 0 immediately. After release, a new `start` with `stream_in`=1 yields 8, not a partial-count sum.
- `start` asserted while in COUNT → no effect on the count or on window length.
